hazard_tnew_tracker: RTL

HAZARD_TNEW_TRACKER -- requirements
Module: hazard_tnew_tracker

---
 rtl/hazard_tnew_tracker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_tnew_tracker.sv
// hazard_tnew_tracker
// Tracks the destination registers of the instructions in E, M and W
// together with their remaining tnew. From these entries it derives the
// ID-stage stall and the forwarding selects for both sources. A small
// counter models the latency of the multiply/divide unit so that
// md-dependent instructions in ID wait until HI/LO are ready.
module hazard_tnew_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_wr_en,
  input  logic [4:0] id_wr_addr,
  input  logic [1:0] id_tnew,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [1:0] id_rs_tuse,
  input  logic [1:0] id_rt_tuse,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       id_md_use,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_busy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic [1:0] tnew;
  } entry_t;

  localparam entry_t BUBBLE = '{valid: 1'b0, addr: 5'd0, tnew: 2'd0};

  localparam logic [1:0] FWD_GRF = 2'b00;
  localparam logic [1:0] FWD_E   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_W   = 2'b11;

  localparam logic [3:0] DIV_CYCLES  = 4'd10;
  localparam logic [3:0] MULT_CYCLES = 4'd5;

  entry_t     e_q, m_q, w_q;
  logic       e_md_start_q;
  logic       e_md_div_q;
  logic [3:0] md_cnt_q;

  logic       stall_rs, stall_rt, stall_md;

  // Decrement a tnew value, holding at zero once the result exists.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Resolve one source against the youngest matching entry.
  // Returns {stall, fwd[1:0]}.
  function automatic logic [2:0] resolve(
    input logic [4:0] addr,
    input logic       used,
    input logic [1:0] tuse,
    input entry_t     e,
    input entry_t     m,
    input entry_t     w
  );
    logic       hit;
    logic [1:0] tnew;
    logic [1:0] sel;
    hit  = 1'b0;
    tnew = 2'd0;
    sel  = FWD_GRF;
    if (used && addr != 5'd0) begin
      if (e.valid && e.addr == addr) begin
        hit = 1'b1; tnew = e.tnew; sel = FWD_E;
      end else if (m.valid && m.addr == addr) begin
        hit = 1'b1; tnew = m.tnew; sel = FWD_M;
      end else if (w.valid && w.addr == addr) begin
        hit = 1'b1; tnew = w.tnew; sel = FWD_W;
      end
    end
    if (!hit)
      return {1'b0, FWD_GRF};
    else if (tnew > tuse)
      return {1'b1, FWD_GRF};
    else if (tnew == 2'd0)
      return {1'b0, sel};
    else
      return {1'b0, FWD_GRF};
  endfunction

  // Hazard detection and forwarding select, purely from state and ID inputs.
  always_comb begin
    // NOTE: every output of this block is assigned a default first so no
    // path through it can leave a value held, which would infer a latch.
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    fwd_rs   = FWD_GRF;
    fwd_rt   = FWD_GRF;
    {stall_rs, fwd_rs} = resolve(id_rs_addr, id_rs_used, id_rs_tuse, e_q, m_q, w_q);
    {stall_rt, fwd_rt} = resolve(id_rt_addr, id_rt_used, id_rt_tuse, e_q, m_q, w_q);
  end

  assign md_busy  = (md_cnt_q != 4'd0) | e_md_start_q;
  assign stall_md = id_md_use & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  // Pipeline tracking entries: E takes the ID instruction or a bubble,
  // M and W age the older entries by one cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let M and W sample the old E and M
    // values on the same edge, modelling a real shift between stages.
    if (reset) begin
      e_q          <= BUBBLE;
      m_q          <= BUBBLE;
      w_q          <= BUBBLE;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
    end else begin
      if (stall || flush) begin
        e_q          <= BUBBLE;
        e_md_start_q <= 1'b0;
        e_md_div_q   <= 1'b0;
      end else begin
        e_q.valid    <= id_wr_en & (id_wr_addr != 5'd0);
        e_q.addr     <= id_wr_addr;
        e_q.tnew     <= id_tnew;
        e_md_start_q <= id_md_start;
        e_md_div_q   <= id_md_div;
      end
      m_q <= '{valid: e_q.valid, addr: e_q.addr, tnew: sat_dec(e_q.tnew)};
      w_q <= '{valid: m_q.valid, addr: m_q.addr, tnew: sat_dec(m_q.tnew)};
    end
  end

  // Multiply/divide latency counter, started by the md instruction in E.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt_q <= 4'd0;
    else if (e_md_start_q && e_md_div_q)
      md_cnt_q <= DIV_CYCLES;
    else if (e_md_start_q)
      md_cnt_q <= MULT_CYCLES;
    else if (md_cnt_q != 4'd0)
      md_cnt_q <= md_cnt_q - 4'd1;
  end

endmodule
